// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants, types and helpers for the decode-to-execute operand stage.
//   WORD_LENGTH / ADDR_LENGTH / NUM_REGS / CTRL_W : datapath geometry
//   word_t, reg_addr_t, ctrl_t                    : scalar types
//   id_ex_t                                       : payload held in the output register
//   is_reg_nonzero()                              : x0 test used by every hazard term
//   select_operand()                              : operand source priority
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int WORD_LENGTH = 32;
  localparam int ADDR_LENGTH = 5;
  localparam int NUM_REGS    = 32;
  localparam int CTRL_W      = 16;

  typedef logic [WORD_LENGTH-1:0] word_t;
  typedef logic [ADDR_LENGTH-1:0] reg_addr_t;
  typedef logic [CTRL_W-1:0]      ctrl_t;

  typedef struct packed {
    word_t     pc;
    word_t     imm;
    word_t     rs1_val;
    word_t     rs2_val;
    reg_addr_t rd;
    logic      rd_we;
    ctrl_t     ctrl;
  } id_ex_t;

  localparam reg_addr_t REG_ZERO = {ADDR_LENGTH{1'b0}};

  function automatic logic is_reg_nonzero(input reg_addr_t addr);
    return (addr != REG_ZERO);
  endfunction

  // x0 beats everything, the execute-stage forward beats the writeback, and the
  // writeback beats the regfile because the regfile only commits it at the edge.
  function automatic word_t select_operand(
    input reg_addr_t addr,
    input logic      fwd_hit,
    input word_t     fwd_val,
    input logic      wb_en,
    input reg_addr_t wb_addr,
    input word_t     wb_val,
    input word_t     rf_val
  );
    word_t val;
    if (addr == REG_ZERO) begin
      val = {WORD_LENGTH{1'b0}};
    end else if (fwd_hit) begin
      val = fwd_val;
    end else if (wb_en && (wb_addr == addr)) begin
      val = wb_val;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

endpackage

// File: rtl/riscv_operand_stage_if.sv
// -----------------------------------------------------------------------------
// riscv_operand_stage_if
// Decode-side (in_*) and execute-side (out_*) valid/ready buses of the operand
// stage, bundled together.
//   master : decoder/execute side (drives in_*, out_ready)
//   slave  : the operand stage    (drives in_ready, out_*)
// -----------------------------------------------------------------------------
interface riscv_operand_stage_if;
  import riscv_pkg::*;

  logic      in_valid;
  logic      in_ready;
  word_t     in_pc;
  word_t     in_imm;
  reg_addr_t in_rs1;
  reg_addr_t in_rs2;
  reg_addr_t in_rd;
  logic      in_rd_we;
  ctrl_t     in_ctrl;

  logic      out_valid;
  logic      out_ready;
  word_t     out_pc;
  word_t     out_imm;
  word_t     out_rs1_val;
  word_t     out_rs2_val;
  reg_addr_t out_rd;
  logic      out_rd_we;
  ctrl_t     out_ctrl;

  modport master (
    output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_rd_we, in_ctrl,
    input  in_ready,
    input  out_valid, out_pc, out_imm, out_rs1_val, out_rs2_val, out_rd, out_rd_we, out_ctrl,
    output out_ready
  );

  modport slave (
    input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_rd_we, in_ctrl,
    output in_ready,
    output out_valid, out_pc, out_imm, out_rs1_val, out_rs2_val, out_rd, out_rd_we, out_ctrl,
    input  out_ready
  );

endinterface

// File: rtl/riscv_scoreboard.sv
// -----------------------------------------------------------------------------
// riscv_scoreboard
// Busy vector of in-flight destination registers.
//   clk, rst_n            : clock, asynchronous active-low reset (clears all busy)
//   set_en / set_addr     : mark a register busy (an rd_we instruction issued)
//   clr_en / clr_addr     : clear a register (writeback or release)
//   q_rs1/q_rs2/q_rd      : hazard query addresses (two sources plus destination)
//   q_*_busy              : address is nonzero, busy, and not being cleared now
// A set and a clear on the same register in one cycle leave it busy.
// -----------------------------------------------------------------------------
module riscv_scoreboard
  import riscv_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t q_rs1,
  input  reg_addr_t q_rs2,
  input  reg_addr_t q_rd,
  output logic      q_rs1_busy,
  output logic      q_rs2_busy,
  output logic      q_rd_busy
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;

  // A clear landing this cycle already resolves the dependency, so it hides busy.
  function automatic logic busy_query(
    input logic [NUM_REGS-1:0] busy,
    input logic [NUM_REGS-1:0] clr_mask,
    input reg_addr_t           addr
  );
    return busy[addr] && !clr_mask[addr] && is_reg_nonzero(addr);
  endfunction

  // One-hot set/clear masks; x0 is never marked busy.
  always_comb begin
    set_mask_s = {NUM_REGS{1'b0}};
    clr_mask_s = {NUM_REGS{1'b0}};
    if (set_en && is_reg_nonzero(set_addr)) begin
      set_mask_s[set_addr] = 1'b1;
    end else begin
      set_mask_s = {NUM_REGS{1'b0}};
    end
    if (clr_en) begin
      clr_mask_s[clr_addr] = 1'b1;
    end else begin
      clr_mask_s = {NUM_REGS{1'b0}};
    end
    // set applied after clear so it wins on a collision
    busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Hazard query for the three addresses of the incoming instruction.
  always_comb begin
    q_rs1_busy = busy_query(busy_r, clr_mask_s, q_rs1);
    q_rs2_busy = busy_query(busy_r, clr_mask_s, q_rs2);
    q_rd_busy  = busy_query(busy_r, clr_mask_s, q_rd);
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

endmodule

// File: rtl/riscv_operand_stage.sv
// -----------------------------------------------------------------------------
// riscv_operand_stage
// Decode-to-execute operand stage: reads rs1/rs2 from the async regfile ports,
// bypasses a same-cycle writeback, stalls RAW/WAW hazards against a busy
// scoreboard and against the instruction still held here, and holds the issued
// instruction in a one-entry valid/ready register feeding execute.
//   clk, rst_n                : clock, asynchronous active-low reset
//   bus (slave)               : in_* from decode, out_* to execute
//   rf_read_addr1/2           : = in_rs1/in_rs2 (combinational)
//   rf_read_data1/2           : regfile async read data
//   wb_write_en/addr, wb_data : writeback (same net as the regfile write)
//   wb_release                : free busy[wb_write_addr] without a write
//   flush                     : drop the output register; blocks accept this cycle
// Optional build macro RISCV_OPERAND_FWD_EN adds fwd_valid/fwd_rd/fwd_data: an
// execute result selectable as an operand that also suppresses the busy stall
// for that source. Without it the stage relies on the scoreboard stall alone.
// -----------------------------------------------------------------------------
module riscv_operand_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_operand_stage_if.slave  bus,
  output reg_addr_t             rf_read_addr1,
  output reg_addr_t             rf_read_addr2,
  input  word_t                 rf_read_data1,
  input  word_t                 rf_read_data2,
  input  logic                  wb_write_en,
  input  reg_addr_t             wb_write_addr,
  input  word_t                 wb_data,
  input  logic                  wb_release,
`ifdef RISCV_OPERAND_FWD_EN
  input  logic                  fwd_valid,
  input  reg_addr_t             fwd_rd,
  input  word_t                 fwd_data,
`endif
  input  logic                  flush
);

  id_ex_t out_r;
  logic   out_valid_r;
  id_ex_t out_next_s;

  logic   rs1_fwd_s;
  logic   rs2_fwd_s;
  word_t  fwd_data_s;
  logic   rs1_busy_s;
  logic   rs2_busy_s;
  logic   rd_busy_s;
  logic   rs1_held_s;
  logic   rs2_held_s;
  logic   rd_held_s;
  logic   hazard_s;
  logic   in_ready_s;
  logic   accept_s;
  logic   issue_s;
  logic   sb_set_en_s;
  logic   sb_clr_en_s;

  assign rf_read_addr1 = bus.in_rs1;
  assign rf_read_addr2 = bus.in_rs2;

`ifdef RISCV_OPERAND_FWD_EN
  // Execute-result hit per source; x0 never matches.
  always_comb begin
    rs1_fwd_s  = fwd_valid && (fwd_rd == bus.in_rs1) && is_reg_nonzero(bus.in_rs1);
    rs2_fwd_s  = fwd_valid && (fwd_rd == bus.in_rs2) && is_reg_nonzero(bus.in_rs2);
    fwd_data_s = fwd_data;
  end
`else
  assign rs1_fwd_s  = 1'b0;
  assign rs2_fwd_s  = 1'b0;
  assign fwd_data_s = {WORD_LENGTH{1'b0}};
`endif

  // The held entry has not set busy yet, so its rd must be matched directly;
  // the execute forward cannot cover it because it has not executed.
  always_comb begin
    rs1_held_s = out_valid_r && out_r.rd_we && (out_r.rd == bus.in_rs1) && is_reg_nonzero(bus.in_rs1);
    rs2_held_s = out_valid_r && out_r.rd_we && (out_r.rd == bus.in_rs2) && is_reg_nonzero(bus.in_rs2);
    rd_held_s  = out_valid_r && out_r.rd_we && (out_r.rd == bus.in_rd)  && is_reg_nonzero(bus.in_rd);
  end

  // Stall decision for the instruction on in_*.
  always_comb begin
    hazard_s = 1'b0;
    if ((rs1_busy_s && !rs1_fwd_s) || rs1_held_s) begin
      hazard_s = 1'b1;
    end else if ((rs2_busy_s && !rs2_fwd_s) || rs2_held_s) begin
      hazard_s = 1'b1;
    end else if (bus.in_rd_we && (rd_busy_s || rd_held_s)) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Handshake: in_ready is independent of in_valid to keep decode loop-free.
  always_comb begin
    in_ready_s  = !hazard_s && (!out_valid_r || bus.out_ready) && !flush;
    accept_s    = bus.in_valid && in_ready_s;
    issue_s     = out_valid_r && bus.out_ready;
    // a flushed entry that is consumed the same cycle still reached execute
    sb_set_en_s = issue_s && out_r.rd_we;
    sb_clr_en_s = wb_write_en || wb_release;
  end

  assign bus.in_ready = in_ready_s;

  // Next output-register contents: in_* passthrough plus resolved operands.
  always_comb begin
    out_next_s.pc      = bus.in_pc;
    out_next_s.imm     = bus.in_imm;
    out_next_s.rd      = bus.in_rd;
    out_next_s.rd_we   = bus.in_rd_we;
    out_next_s.ctrl    = bus.in_ctrl;
    out_next_s.rs1_val = select_operand(bus.in_rs1, rs1_fwd_s, fwd_data_s,
                                        wb_write_en, wb_write_addr, wb_data, rf_read_data1);
    out_next_s.rs2_val = select_operand(bus.in_rs2, rs2_fwd_s, fwd_data_s,
                                        wb_write_en, wb_write_addr, wb_data, rf_read_data2);
  end

  // One-entry output register; data only moves on accept so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_r       <= {$bits(id_ex_t){1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_r       <= out_next_s;
    end else if (flush || issue_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.out_pc      = out_r.pc;
  assign bus.out_imm     = out_r.imm;
  assign bus.out_rs1_val = out_r.rs1_val;
  assign bus.out_rs2_val = out_r.rs2_val;
  assign bus.out_rd      = out_r.rd;
  assign bus.out_rd_we   = out_r.rd_we;
  assign bus.out_ctrl    = out_r.ctrl;

  riscv_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (sb_set_en_s),
    .set_addr   (out_r.rd),
    .clr_en     (sb_clr_en_s),
    .clr_addr   (wb_write_addr),
    .q_rs1      (bus.in_rs1),
    .q_rs2      (bus.in_rs2),
    .q_rd       (bus.in_rd),
    .q_rs1_busy (rs1_busy_s),
    .q_rs2_busy (rs2_busy_s),
    .q_rd_busy  (rd_busy_s)
  );

endmodule
